// File: rtl/clock_pkg.sv
// Shared types and constants for the BCD time-of-day counter.
//   mode_t       - set-mode FSM state, encoding is visible on the mode output
//   bcd_digit_t  - one BCD digit
//   DOTS_HHMMSS  - decimal-point pattern marking the hh.mm.ss separators
//   mode_succ()  - the state that btn_mode advances to
package clock_pkg;

  typedef enum logic [2:0] {
    MODE_RUN         = 3'd0,
    MODE_SET_HOUR    = 3'd1,
    MODE_SET_MIN     = 3'd2,
    MODE_SET_AL_HOUR = 3'd3,
    MODE_SET_AL_MIN  = 3'd4
  } mode_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] DOTS_HHMMSS = 8'h14;

  // Successor of each legal state under btn_mode; anything else lands in RUN.
  function automatic mode_t mode_succ(input mode_t m);
    mode_t r;
    case (m)
      MODE_RUN:         r = MODE_SET_HOUR;
      MODE_SET_HOUR:    r = MODE_SET_MIN;
      MODE_SET_MIN:     r = MODE_SET_AL_HOUR;
      MODE_SET_AL_HOUR: r = MODE_SET_AL_MIN;
      default:          r = MODE_RUN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter that wraps from {MAX_T,MAX_U} back to 00.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset (loads RESET_VAL)
//   i_inc          - advance by one this cycle
//   i_clr          - force 00 this cycle (wins over i_inc)
//   o_tens/o_units - current digits
//   o_next_tens/o_next_units - value the pair will hold after this edge
//   o_carry        - high in the cycle an increment wraps the pair to 00
module bcd_digit_pair
  import clock_pkg::*;
#(
  parameter logic [3:0] MAX_T     = 4'd5,
  parameter logic [3:0] MAX_U     = 4'd9,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_clr,
  output bcd_digit_t o_tens,
  output bcd_digit_t o_units,
  output bcd_digit_t o_next_tens,
  output bcd_digit_t o_next_units,
  output logic       o_carry
);

  bcd_digit_t r_tens;
  bcd_digit_t r_units;
  bcd_digit_t w_tens_next;
  bcd_digit_t w_units_next;
  logic       w_at_max;

  assign w_at_max = (r_tens == MAX_T) && (r_units == MAX_U);

  always_comb begin
    w_tens_next  = r_tens;
    w_units_next = r_units;
    if (i_clr) begin
      w_tens_next  = 4'd0;
      w_units_next = 4'd0;
    end else if (i_inc) begin
      if (w_at_max) begin
        w_tens_next  = 4'd0;
        w_units_next = 4'd0;
      end else if (r_units == 4'd9) begin
        // Units roll over inside the range (e.g. 09 -> 10, 19 -> 20).
        w_tens_next  = r_tens + 4'd1;
        w_units_next = 4'd0;
      end else begin
        w_units_next = r_units + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tens  <= RESET_VAL[7:4];
      r_units <= RESET_VAL[3:0];
    end else begin
      r_tens  <= w_tens_next;
      r_units <= w_units_next;
    end
  end

  assign o_tens       = r_tens;
  assign o_units      = r_units;
  assign o_next_tens  = w_tens_next;
  assign o_next_units = w_units_next;
  assign o_carry      = i_inc & ~i_clr & w_at_max;

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour hh:mm:ss counter kept in BCD, with a button-driven set mode and an
// LED alarm that stays lit for ALARM_SECS ticks after the time reaches
// alarm_h:alarm_m:00.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   tick       - one-cycle pulse per second, advances time
//   btn_mode   - one-cycle pulse, RUN -> SET_HOUR -> SET_MIN -> SET_AL_HOUR -> SET_AL_MIN -> RUN
//   btn_up     - one-cycle pulse, increments the selected field or dismisses the alarm in RUN
//   bcd        - {BLANK,BLANK,hh,mm,ss} or {BLANK,BLANK,alarm hh,alarm mm,BLANK,BLANK}
//   dots       - fixed separator pattern
//   mode       - current FSM state
//   alarm_led  - alarm indicator
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned ALARM_SECS    = 30,
  parameter logic [7:0]  ALARM_RESET_H = 8'h06,
  parameter logic [7:0]  ALARM_RESET_M = 8'h00,
  parameter logic [3:0]  BLANK_NIBBLE  = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_up,
  output logic [31:0] bcd,
  output logic [7:0]  dots,
  output logic [2:0]  mode,
  output logic        alarm_led
);

  localparam logic [7:0] ALARM_LOAD = 8'(ALARM_SECS);

  mode_t      r_mode;
  mode_t      w_mode_next;
  logic       r_alarm_led;
  logic [7:0] r_alarm_cnt;

  logic       w_up;
  logic       w_time_run;
  logic       w_sec_inc, w_sec_clr, w_min_inc, w_hour_inc, w_al_h_inc, w_al_m_inc;
  logic       w_sec_carry, w_min_carry;
  logic       w_match;

  bcd_digit_t w_s_t, w_s_u, w_m_t, w_m_u, w_h_t, w_h_u;
  bcd_digit_t w_m_next_t, w_m_next_u, w_h_next_t, w_h_next_u;
  bcd_digit_t w_al_h_t, w_al_h_u, w_al_m_t, w_al_m_u;

  logic       w_unused_hour_carry;
  bcd_digit_t w_unused_s_next_t, w_unused_s_next_u;
  bcd_digit_t w_unused_al_h_next_t, w_unused_al_h_next_u;
  bcd_digit_t w_unused_al_m_next_t, w_unused_al_m_next_u;
  logic       w_unused_al_h_carry, w_unused_al_m_carry;

  // btn_mode takes the cycle; a simultaneous btn_up is dropped.
  assign w_up       = btn_up & ~btn_mode;
  assign w_time_run = (r_mode != MODE_SET_HOUR) && (r_mode != MODE_SET_MIN);

  assign w_sec_inc  = tick & w_time_run;
  assign w_sec_clr  = btn_mode & (r_mode == MODE_RUN);
  assign w_min_inc  = w_sec_carry | (w_up & (r_mode == MODE_SET_MIN));
  // Minute carry only reaches the hours when it came from the seconds chain,
  // so a minute edit wrapping 59 -> 00 leaves the hour alone.
  assign w_hour_inc = (w_sec_carry & w_min_carry) | (w_up & (r_mode == MODE_SET_HOUR));
  assign w_al_h_inc = w_up & (r_mode == MODE_SET_AL_HOUR);
  assign w_al_m_inc = w_up & (r_mode == MODE_SET_AL_MIN);

  bcd_digit_pair #(.MAX_T(4'd5), .MAX_U(4'd9), .RESET_VAL(8'h00)) u_sec (
    .clk(clk), .reset(reset), .i_inc(w_sec_inc), .i_clr(w_sec_clr),
    .o_tens(w_s_t), .o_units(w_s_u),
    .o_next_tens(w_unused_s_next_t), .o_next_units(w_unused_s_next_u),
    .o_carry(w_sec_carry)
  );

  bcd_digit_pair #(.MAX_T(4'd5), .MAX_U(4'd9), .RESET_VAL(8'h00)) u_min (
    .clk(clk), .reset(reset), .i_inc(w_min_inc), .i_clr(1'b0),
    .o_tens(w_m_t), .o_units(w_m_u),
    .o_next_tens(w_m_next_t), .o_next_units(w_m_next_u),
    .o_carry(w_min_carry)
  );

  bcd_digit_pair #(.MAX_T(4'd2), .MAX_U(4'd3), .RESET_VAL(8'h00)) u_hour (
    .clk(clk), .reset(reset), .i_inc(w_hour_inc), .i_clr(1'b0),
    .o_tens(w_h_t), .o_units(w_h_u),
    .o_next_tens(w_h_next_t), .o_next_units(w_h_next_u),
    .o_carry(w_unused_hour_carry)
  );

  bcd_digit_pair #(.MAX_T(4'd2), .MAX_U(4'd3), .RESET_VAL(ALARM_RESET_H)) u_al_hour (
    .clk(clk), .reset(reset), .i_inc(w_al_h_inc), .i_clr(1'b0),
    .o_tens(w_al_h_t), .o_units(w_al_h_u),
    .o_next_tens(w_unused_al_h_next_t), .o_next_units(w_unused_al_h_next_u),
    .o_carry(w_unused_al_h_carry)
  );

  bcd_digit_pair #(.MAX_T(4'd5), .MAX_U(4'd9), .RESET_VAL(ALARM_RESET_M)) u_al_min (
    .clk(clk), .reset(reset), .i_inc(w_al_m_inc), .i_clr(1'b0),
    .o_tens(w_al_m_t), .o_units(w_al_m_u),
    .o_next_tens(w_unused_al_m_next_t), .o_next_units(w_unused_al_m_next_u),
    .o_carry(w_unused_al_m_carry)
  );

  // A seconds wrap means the new time is hh:mm:00; compare the post-tick
  // hours/minutes with the alarm. Alarm edits alone can never fire this.
  assign w_match = w_sec_carry &&
                   ({w_h_next_t, w_h_next_u} == {w_al_h_t, w_al_h_u}) &&
                   ({w_m_next_t, w_m_next_u} == {w_al_m_t, w_al_m_u});

  // Mode FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= MODE_RUN;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  // Mode FSM: next state. Unused codes fall back to RUN without a button.
  always_comb begin
    w_mode_next = r_mode;
    case (r_mode)
      MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN, MODE_SET_AL_HOUR, MODE_SET_AL_MIN: begin
        if (btn_mode) begin
          w_mode_next = mode_succ(r_mode);
        end
      end
      default: w_mode_next = MODE_RUN;
    endcase
  end

  // Alarm: a match (re)loads the duration; the LED is lit exactly while the
  // counter is non-zero, so it drops on the tick that brings it to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm_led <= 1'b0;
      r_alarm_cnt <= 8'd0;
    end else if (w_match) begin
      r_alarm_led <= 1'b1;
      r_alarm_cnt <= ALARM_LOAD;
    end else if ((r_mode == MODE_RUN) && w_up && r_alarm_led) begin
      r_alarm_led <= 1'b0;
      r_alarm_cnt <= 8'd0;
    end else if (tick && (r_alarm_cnt != 8'd0)) begin
      r_alarm_cnt <= r_alarm_cnt - 8'd1;
      if (r_alarm_cnt == 8'd1) begin
        r_alarm_led <= 1'b0;
      end
    end
  end

  always_comb begin
    bcd = {BLANK_NIBBLE, BLANK_NIBBLE, w_h_t, w_h_u, w_m_t, w_m_u, w_s_t, w_s_u};
    if ((r_mode == MODE_SET_AL_HOUR) || (r_mode == MODE_SET_AL_MIN)) begin
      bcd = {BLANK_NIBBLE, BLANK_NIBBLE, w_al_h_t, w_al_h_u, w_al_m_t, w_al_m_u,
             BLANK_NIBBLE, BLANK_NIBBLE};
    end
  end

  assign dots      = DOTS_HHMMSS;
  assign mode      = r_mode;
  assign alarm_led = r_alarm_led;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter. A behavioural model (plain integer
// hours/minutes/seconds) predicts every cycle; predictions are queued when the
// stimulus is applied and compared with the captured DUT outputs afterwards.
module tb_bcd_time_counter;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        btn_mode;
  logic        btn_up;
  logic [31:0] bcd;
  logic [7:0]  dots;
  logic [2:0]  mode;
  logic        alarm_led;

  bcd_time_counter dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_up(btn_up),
    .bcd(bcd), .dots(dots), .mode(mode), .alarm_led(alarm_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int ALARM_SECS = 30;

  logic [43:0] exp_q[$];
  logic [43:0] obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state
  int m_h, m_m, m_s, m_ah, m_am, m_mode, m_cnt;
  bit m_led;

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [43:0] model_out();
    logic [31:0] b;
    if (m_mode == 3 || m_mode == 4)
      b = {8'hFF, to_bcd2(m_ah), to_bcd2(m_am), 8'hFF};
    else
      b = {8'hFF, to_bcd2(m_h), to_bcd2(m_m), to_bcd2(m_s)};
    return {b, 8'h14, 3'(m_mode), m_led};
  endfunction

  task automatic model_step(input bit r, input bit t, input bit m, input bit u);
    bit up, frozen, match;
    if (r) begin
      m_h = 0; m_m = 0; m_s = 0; m_ah = 6; m_am = 0;
      m_mode = 0; m_led = 0; m_cnt = 0;
      return;
    end
    up = u && !m;
    frozen = (m_mode == 1) || (m_mode == 2);
    match = 0;
    if (m && m_mode == 0) begin
      m_s = 0;
    end else if (t && !frozen) begin
      m_s = m_s + 1;
      if (m_s == 60) begin
        m_s = 0;
        m_m = m_m + 1;
        if (m_m == 60) begin
          m_m = 0;
          m_h = (m_h + 1) % 24;
        end
        match = (m_h == m_ah) && (m_m == m_am);
      end
    end
    if (match) begin
      m_led = 1; m_cnt = ALARM_SECS;
    end else if (m_mode == 0 && up && m_led) begin
      m_led = 0; m_cnt = 0;
    end else if (t && m_led) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_led = 0;
    end
    if (up) begin
      case (m_mode)
        1: m_h  = (m_h + 1) % 24;
        2: m_m  = (m_m + 1) % 60;
        3: m_ah = (m_ah + 1) % 24;
        4: m_am = (m_am + 1) % 60;
        default: ;
      endcase
    end
    if (m) m_mode = (m_mode + 1) % 5;
  endtask

  // Apply one cycle of stimulus, queue the prediction, capture the DUT result.
  task automatic step(input bit r, input bit t, input bit m, input bit u);
    reset = r; tick = t; btn_mode = m; btn_up = u;
    model_step(r, t, m, u);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    obs_q.push_back({bcd, dots, mode, alarm_led});
    cyc++;
    reset = 0; tick = 0; btn_mode = 0; btn_up = 0;
  endtask

  task automatic test_reset();
    logic [43:0] e, o;
    step(1, 1, 0, 1);   // reset wins over tick and btn_up
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL reset_cycle: got %h want %h", o, e);
      else begin n_pass++; $display("cycle %0d reset bcd=%h mode=%0d led=%b", cyc, o[43:12], o[3:1], o[0]); end
    end
    n_checks++;
    if (bcd !== 32'hFF00_0000 || dots !== 8'h14 || mode !== 3'd0 || alarm_led !== 1'b0)
      $display("FAIL reset_values: got bcd=%h dots=%h mode=%0d led=%b want FF000000/14/0/0", bcd, dots, mode, alarm_led);
    else n_pass++;
  endtask

  task automatic test_run_count();
    logic [43:0] e, o;
    for (int i = 0; i < 61; i++) begin
      step(0, 1, 0, 0);
      if (i % 7 == 3) step(0, 0, 0, 0);   // uneven spacing between ticks
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL run_count_cycle: got %h want %h", o, e);
      else begin n_pass++; $display("cycle %0d run bcd=%h mode=%0d led=%b", cyc, o[43:12], o[3:1], o[0]); end
    end
    n_checks++;
    if (bcd !== 32'hFF00_0101 || alarm_led !== 1'b0 || mode !== 3'd0)
      $display("FAIL run_count_61: got bcd=%h led=%b mode=%0d want FF000101/0/0", bcd, alarm_led, mode);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [43:0] e, o;
    step(0, 0, 1, 0);                              // SET_HOUR, seconds cleared
    for (int i = 0; i < 23; i++) step(0, 0, 0, 1); // 00 -> 23
    step(0, 0, 1, 0);                              // SET_MIN
    for (int i = 0; i < 58; i++) step(0, 0, 0, 1); // 01 -> 59
    step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);   // back to RUN
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL wrap_cycle: got %h want %h", o, e);
      else begin n_pass++; $display("cycle %0d wrap bcd=%h mode=%0d led=%b", cyc, o[43:12], o[3:1], o[0]); end
    end
    n_checks++;
    if (bcd !== 32'hFF23_5959) $display("FAIL wrap_preload: got %h want FF235959", bcd);
    else n_pass++;
    step(0, 1, 0, 0);
    e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
    if (o !== e) $display("FAIL wrap_midnight_cycle: got %h want %h", o, e);
    else n_pass++;
    n_checks++;
    if (bcd !== 32'hFF00_0000) $display("FAIL wrap_midnight: got %h want FF000000", bcd);
    else n_pass++;
  endtask

  task automatic test_set_hour();
    logic [43:0] e, o;
    step(0, 0, 1, 0);                              // SET_HOUR
    for (int i = 0; i < 25; i++) step(0, 0, 0, 1); // 23 -> 00 -> 01 wrap
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL set_hour_cycle: got %h want %h", o, e);
      else begin n_pass++; $display("cycle %0d set_hour bcd=%h mode=%0d led=%b", cyc, o[43:12], o[3:1], o[0]); end
    end
    n_checks++;
    if (bcd !== 32'hFF01_0000 || mode !== 3'd1) $display("FAIL set_hour_value: got bcd=%h mode=%0d want FF010000/1", bcd, mode);
    else n_pass++;
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);  // frozen
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);  // back to RUN
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL set_hour_frozen_cycle: got %h want %h", o, e);
      else begin n_pass++; $display("cycle %0d set_hour bcd=%h mode=%0d led=%b", cyc, o[43:12], o[3:1], o[0]); end
    end
    n_checks++;
    if (bcd !== 32'hFF01_0000 || mode !== 3'd0) $display("FAIL set_hour_frozen: got bcd=%h mode=%0d want FF010000/0", bcd, mode);
    else n_pass++;
  endtask

  task automatic test_alarm();
    logic [43:0] e, o;
    int first_rise, hi_cnt;
    step(0, 0, 1, 0);                              // SET_HOUR
    for (int i = 0; i < 23; i++) step(0, 0, 0, 1); // 01 -> 00
    step(0, 0, 1, 0);                              // SET_MIN
    step(0, 0, 0, 1);                              // 00 -> 01
    step(0, 0, 1, 0);                              // SET_AL_HOUR
    n_checks++;
    if (bcd !== 32'hFF06_00FF) $display("FAIL alarm_show_default: got %h want FF0600FF", bcd);
    else n_pass++;
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1); // 06 -> 00
    step(0, 0, 1, 0);                              // SET_AL_MIN
    step(0, 0, 0, 1); step(0, 0, 0, 1);            // 00 -> 02
    n_checks++;
    if (bcd !== 32'hFF00_02FF) $display("FAIL alarm_show_set: got %h want FF0002FF", bcd);
    else n_pass++;
    step(0, 0, 1, 0);                              // RUN at 00:01:00
    n_checks++;
    if (bcd !== 32'hFF00_0100 || mode !== 3'd0) $display("FAIL alarm_start_time: got bcd=%h mode=%0d want FF000100/0", bcd, mode);
    else n_pass++;
    first_rise = -1; hi_cnt = 0;
    for (int i = 1; i <= 95; i++) begin
      step(0, 1, 0, 0);
      if (alarm_led === 1'b1 && first_rise < 0) first_rise = i;
      if (alarm_led === 1'b1) hi_cnt++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL alarm_cycle: got %h want %h", o, e);
      else begin n_pass++; $display("cycle %0d alarm bcd=%h mode=%0d led=%b", cyc, o[43:12], o[3:1], o[0]); end
    end
    n_checks++;
    if (first_rise !== 60) $display("FAIL alarm_rise_tick: got %0d want 60", first_rise);
    else n_pass++;
    n_checks++;
    if (hi_cnt !== ALARM_SECS) $display("FAIL alarm_duration: got %0d want %0d", hi_cnt, ALARM_SECS);
    else n_pass++;
  endtask

  task automatic test_dismiss_and_collision();
    logic [43:0] e, o;
    step(0, 0, 1, 0);                                // SET_HOUR, 00:02:00
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);    // -> SET_AL_MIN
    step(0, 0, 0, 1);                                // alarm minute 02 -> 03
    step(0, 0, 1, 0);                                // RUN
    for (int i = 0; i < 60; i++) step(0, 1, 0, 0);   // -> 00:03:00
    n_checks++;
    if (alarm_led !== 1'b1 || bcd !== 32'hFF00_0300) $display("FAIL dismiss_trigger: got led=%b bcd=%h want 1/FF000300", alarm_led, bcd);
    else n_pass++;
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 1);                                // dismiss
    n_checks++;
    if (alarm_led !== 1'b0 || mode !== 3'd0) $display("FAIL dismiss_led: got led=%b mode=%0d want 0/0", alarm_led, mode);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 1);                                // mode wins, seconds cleared
    n_checks++;
    if (mode !== 3'd1 || bcd !== 32'hFF00_0300) $display("FAIL collision_run: got mode=%0d bcd=%h want 1/FF000300", mode, bcd);
    else n_pass++;
    step(0, 0, 1, 1);                                // hour must not move
    n_checks++;
    if (mode !== 3'd2 || bcd !== 32'hFF00_0300) $display("FAIL collision_set_hour: got mode=%0d bcd=%h want 2/FF000300", mode, bcd);
    else n_pass++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL dismiss_cycle: got %h want %h", o, e);
      else begin n_pass++; $display("cycle %0d dismiss bcd=%h mode=%0d led=%b", cyc, o[43:12], o[3:1], o[0]); end
    end
  endtask

  task automatic test_reset_mid_set();
    logic [43:0] e, o;
    step(0, 0, 1, 0); step(0, 0, 1, 0);              // SET_MIN -> SET_AL_MIN
    step(0, 0, 0, 1);                                // alarm minute 03 -> 04
    step(0, 0, 1, 0);                                // RUN at 00:03:00
    for (int i = 0; i < 60; i++) step(0, 1, 0, 0);   // -> 00:04:00 alarm
    step(0, 0, 1, 0); step(0, 0, 1, 0);              // SET_MIN, alarm kept
    n_checks++;
    if (alarm_led !== 1'b1 || mode !== 3'd2) $display("FAIL alarm_kept_in_set: got led=%b mode=%0d want 1/2", alarm_led, mode);
    else n_pass++;
    step(1, 1, 1, 1);                                // reset wins over all
    n_checks++;
    if (bcd !== 32'hFF00_0000 || dots !== 8'h14 || mode !== 3'd0 || alarm_led !== 1'b0)
      $display("FAIL reset_mid_set: got bcd=%h dots=%h mode=%0d led=%b want FF000000/14/0/0", bcd, dots, mode, alarm_led);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);    // SET_AL_HOUR
    n_checks++;
    if (bcd !== 32'hFF06_00FF) $display("FAIL reset_alarm_value: got %h want FF0600FF", bcd);
    else n_pass++;
    step(1, 0, 0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) $display("FAIL reset_mid_set_cycle: got %h want %h", o, e);
      else begin n_pass++; $display("cycle %0d reset_mid_set bcd=%h mode=%0d led=%b", cyc, o[43:12], o[3:1], o[0]); end
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
    test_reset();
    test_run_count();
    test_wrap();
    test_set_hour();
    test_alarm();
    test_dismiss_and_collision();
    test_reset_mid_set();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
